// File: rtl/refill_pkg.sv
// Shared FSM state type and width helpers for the refill line responder.
package refill_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StIssue    = 2'd1,
        StWaitResp = 2'd2,
        StResp     = 2'd3
    } refill_state_e;

    function automatic int unsigned calc_nb_beats(input int unsigned refill_w,
                                                  input int unsigned mem_w);
        return refill_w / mem_w;
    endfunction

    function automatic int unsigned calc_beat_idx_w(input int unsigned refill_w,
                                                    input int unsigned mem_w);
        return $clog2(refill_w / mem_w);
    endfunction

    function automatic int unsigned calc_line_off_w(input int unsigned refill_w);
        return $clog2(refill_w / 8);
    endfunction

    function automatic int unsigned calc_beat_off_w(input int unsigned mem_w);
        return $clog2(mem_w / 8);
    endfunction

    // Values for the default 128-bit line / 32-bit beat configuration.
    localparam int unsigned NB_BEATS   = calc_nb_beats(128, 32);
    localparam int unsigned BEAT_IDX_W = calc_beat_idx_w(128, 32);
    localparam int unsigned LINE_OFF_W = calc_line_off_w(128);
    localparam int unsigned BEAT_OFF_W = calc_beat_off_w(32);

endpackage

// File: rtl/refill_line_buffer.sv
// Slot-indexed beat assembly buffer with a registered line output that only
// updates when a complete line is committed.
module refill_line_buffer
    import refill_pkg::*;
#(
    parameter int unsigned REFILL_DATA_WIDTH = 128,
    parameter int unsigned MEM_DATA_WIDTH    = 32,
    parameter int unsigned NB_BEATS          = 4,
    parameter int unsigned BEAT_IDX_W        = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [BEAT_IDX_W-1:0]        wr_idx,
    input  logic [MEM_DATA_WIDTH-1:0]    wr_data,
    input  logic                         commit,
    output logic [REFILL_DATA_WIDTH-1:0] line
);

    logic [REFILL_DATA_WIDTH-1:0] line_buf_q;
    logic [REFILL_DATA_WIDTH-1:0] line_buf_d;
    logic [REFILL_DATA_WIDTH-1:0] line_q;

    always_comb begin
        line_buf_d = line_buf_q;
        if (clear) begin
            line_buf_d = '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB_BEATS; i++) begin
                if (wr_idx == BEAT_IDX_W'(i)) begin
                    line_buf_d[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = wr_data;
                end
            end
        end
    end

    // Commit samples the next-state buffer so the final beat lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_buf_q <= '0;
            line_q     <= '0;
        end else begin
            line_buf_q <= line_buf_d;
            if (commit) begin
                line_q <= line_buf_d;
            end
        end
    end

    assign line = line_q;

endmodule

// File: rtl/refill_line_responder.sv
// Serves one cache-line refill at a time by splitting it into sequential narrow
// memory reads and returning the assembled line as a single-cycle pulse.
module refill_line_responder
    import refill_pkg::*;
#(
    parameter int unsigned FETCH_ADDR_WIDTH  = 32,
    parameter int unsigned REFILL_DATA_WIDTH = 128,
    parameter int unsigned MEM_DATA_WIDTH    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         refill_req_i,
    output logic                         refill_gnt_o,
    input  logic [FETCH_ADDR_WIDTH-1:0]  refill_addr_i,
    output logic                         refill_r_valid_o,
    output logic [REFILL_DATA_WIDTH-1:0] refill_r_data_o,
    output logic                         mem_req_o,
    input  logic                         mem_gnt_i,
    output logic [FETCH_ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic                         mem_r_valid_i,
    input  logic [MEM_DATA_WIDTH-1:0]    mem_r_rdata_i,
    output logic                         busy_o
);

    localparam int unsigned NBEATS   = calc_nb_beats(REFILL_DATA_WIDTH, MEM_DATA_WIDTH);
    localparam int unsigned IDX_W    = calc_beat_idx_w(REFILL_DATA_WIDTH, MEM_DATA_WIDTH);
    localparam int unsigned LINE_OFF = calc_line_off_w(REFILL_DATA_WIDTH);
    localparam int unsigned BEAT_OFF = calc_beat_off_w(MEM_DATA_WIDTH);
    localparam int unsigned CNT_W    = IDX_W + 1;
    localparam int unsigned BASE_W   = FETCH_ADDR_WIDTH - LINE_OFF;

    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(NBEATS - 1);
    localparam logic [CNT_W-1:0] ALL_RX     = CNT_W'(NBEATS);

    refill_state_e     state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic              r_valid_q;
    logic              accept_req;
    logic              rx_accept;
    logic              commit;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^refill_addr_i[LINE_OFF-1:0];

    assign refill_gnt_o = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign mem_req_o    = (state_q == StIssue);
    assign mem_addr_o   = FETCH_ADDR_WIDTH'({base_q, issue_cnt_q[IDX_W-1:0]}) << BEAT_OFF;

    assign accept_req = refill_gnt_o && refill_req_i;

    // A beat response is only legal while a granted beat is still outstanding.
    assign rx_accept = mem_r_valid_i
                    && ((state_q == StIssue) || (state_q == StWaitResp))
                    && (rx_cnt_q != issue_cnt_q);

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        base_d      = base_q;

        if (rx_accept) begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (refill_req_i) begin
                    base_d      = refill_addr_i[FETCH_ADDR_WIDTH-1:LINE_OFF];
                    issue_cnt_d = '0;
                    rx_cnt_d    = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (mem_gnt_i) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    if (issue_cnt_q == LAST_ISSUE) begin
                        state_d = (rx_cnt_d == ALL_RX) ? StResp : StWaitResp;
                    end
                end
            end
            StWaitResp: begin
                if (rx_cnt_d == ALL_RX) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign commit = (state_d == StResp) && (state_q != StResp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            rx_cnt_q    <= '0;
            base_q      <= '0;
            r_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            base_q      <= base_d;
            r_valid_q   <= commit;
        end
    end

    assign refill_r_valid_o = r_valid_q;

    refill_line_buffer #(
        .REFILL_DATA_WIDTH (REFILL_DATA_WIDTH),
        .MEM_DATA_WIDTH    (MEM_DATA_WIDTH),
        .NB_BEATS          (NBEATS),
        .BEAT_IDX_W        (IDX_W)
    ) u_line_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept_req),
        .wr_en   (rx_accept),
        .wr_idx  (rx_cnt_q[IDX_W-1:0]),
        .wr_data (mem_r_rdata_i),
        .commit  (commit),
        .line    (refill_r_data_o)
    );

    spurious_r_valid: assert property (@(posedge clk) disable iff (!rst_n)
        mem_r_valid_i |-> rx_accept)
        else $warning("mem_r_valid_i with no outstanding beat, ignored");

endmodule

// File: tb/tb_refill_line_responder.sv
// Self-checking bench: reactive memory model plus a line-level reference model.
module tb_refill_line_responder;

    localparam int unsigned AW = 32;
    localparam int unsigned RW = 128;
    localparam int unsigned MW = 32;
    localparam int unsigned NB = RW / MW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          refill_req = 1'b0;
    logic          refill_gnt;
    logic [AW-1:0] refill_addr = '0;
    logic          refill_r_valid;
    logic [RW-1:0] refill_r_data;
    logic          mem_req;
    logic          mem_gnt = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rv = 1'b0;
    logic [MW-1:0] mem_rdata = '0;
    logic          busy;

    int passed = 0;
    int total = 0;
    int cyc = 0;

    refill_line_responder #(
        .FETCH_ADDR_WIDTH  (AW),
        .REFILL_DATA_WIDTH (RW),
        .MEM_DATA_WIDTH    (MW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .refill_req_i     (refill_req),
        .refill_gnt_o     (refill_gnt),
        .refill_addr_i    (refill_addr),
        .refill_r_valid_o (refill_r_valid),
        .refill_r_data_o  (refill_r_data),
        .mem_req_o        (mem_req),
        .mem_gnt_i        (mem_gnt),
        .mem_addr_o       (mem_addr),
        .mem_r_valid_i    (mem_rv),
        .mem_r_rdata_i    (mem_rdata),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model knobs and records.
    int unsigned gnt_pct = 100;
    int unsigned dly_min = 1;
    int unsigned dly_max = 1;
    int          stall_beat = -1;
    int          stall_left = 0;
    bit          use_table = 1'b0;
    logic [31:0] table_w [4];
    logic [31:0] salt = 32'h0;
    bit          spur_req = 1'b0;
    logic [31:0] spur_data = 32'h0;
    int          last_rv_cyc = 0;
    int          hold_viol = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t        rspq[$];
    logic [31:0] gaddr[$];
    int          gcyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (use_table) return table_w[a[3:2]];
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Reference: the line is the NB consecutive words from the aligned base, beat 0 at the LSBs.
    function automatic logic [RW-1:0] exp_line(input logic [31:0] addr);
        logic [RW-1:0] l;
        logic [31:0]   base;
        base = addr & ~(32'(RW / 8) - 32'd1);
        l = '0;
        for (int i = 0; i < NB; i++) l[i*MW +: MW] = mem_word(base + 32'(i * (MW / 8)));
        return l;
    endfunction

    initial begin : mem_model
        bit          g;
        bit          prev_stalled;
        logic [31:0] prev_addr;
        rsp_t        r;
        int          due;
        prev_stalled = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            mem_rv = 1'b0;
            mem_rdata = $urandom();
            if (spur_req) begin
                mem_rv = 1'b1;
                mem_rdata = spur_data;
                spur_req = 1'b0;
            end else if (rspq.size() > 0 && rspq[0].due <= cyc) begin
                r = rspq.pop_front();
                mem_rv = 1'b1;
                mem_rdata = mem_word(r.addr);
                last_rv_cyc = cyc;
            end
            g = ($urandom_range(99) < gnt_pct);
            if (mem_req && stall_left > 0 && int'(mem_addr[3:2]) == stall_beat) begin
                g = 1'b0;
                stall_left--;
            end
            if (prev_stalled && !(mem_req && mem_addr == prev_addr)) hold_viol++;
            mem_gnt = g;
            prev_stalled = mem_req && !g;
            prev_addr = mem_addr;
            if (mem_req && g) begin
                due = cyc + int'($urandom_range(dly_max, dly_min));
                if (rspq.size() > 0 && due <= rspq[$].due) due = rspq[$].due + 1;
                rspq.push_back('{addr: mem_addr, due: due});
                gaddr.push_back(mem_addr);
                gcyc.push_back(cyc);
            end
        end
    end

    // Drives one request and observes the response; called at a negedge, returns at a negedge.
    task automatic run_line(input logic [31:0] addr, output logic [RW-1:0] data,
                            output int g_cyc, output int p_cyc, output int width,
                            output bit gnt_at_p, output bit gnt_after, output bit tmo);
        int n;
        tmo = 1'b0; width = 0; gnt_at_p = 1'b1; gnt_after = 1'b0; data = '0;
        g_cyc = -1; p_cyc = -1;
        gaddr.delete();
        gcyc.delete();
        refill_req = 1'b1;
        refill_addr = addr;
        n = 0;
        while (!refill_gnt && n < 50) begin @(negedge clk); n++; end
        if (!refill_gnt) begin tmo = 1'b1; refill_req = 1'b0; return; end
        g_cyc = cyc;
        @(negedge clk);
        refill_req = 1'b0;
        refill_addr = $urandom();
        n = 0;
        while (!refill_r_valid && n < 400) begin @(negedge clk); n++; end
        if (!refill_r_valid) begin tmo = 1'b1; return; end
        p_cyc = cyc;
        data = refill_r_data;
        gnt_at_p = refill_gnt;
        while (refill_r_valid && width < 8) begin width++; @(negedge clk); end
        gnt_after = refill_gnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (refill_gnt !== 1'b1) $display("FAIL reset_gnt: got %b want 1", refill_gnt); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else passed++;
        total++; if (refill_r_valid !== 1'b0) $display("FAIL reset_r_valid: got %b want 0", refill_r_valid); else passed++;
        total++; if (refill_r_data !== '0) $display("FAIL reset_r_data: got %h want 0", refill_r_data); else passed++;
    endtask

    task automatic test_zero_wait();
        logic [RW-1:0] d;
        int g, p, w;
        bit ga, gb, tmo;
        use_table = 1'b1;
        table_w[0] = 32'h1111_1111; table_w[1] = 32'h2222_2222;
        table_w[2] = 32'h3333_3333; table_w[3] = 32'h4444_4444;
        gnt_pct = 100; dly_min = 1; dly_max = 1; stall_left = 0;
        run_line(32'h1C00_0014, d, g, p, w, ga, gb, tmo);
        total++; if (tmo) $display("FAIL zw_timeout: no response within bound"); else passed++;
        total++; if (gaddr.size() != NB) $display("FAIL zw_beat_count: got %0d want %0d", gaddr.size(), NB); else passed++;
        for (int i = 0; i < NB && i < gaddr.size(); i++) begin
            total++;
            if (gaddr[i] !== 32'h1C00_0010 + 32'(4 * i))
                $display("FAIL zw_beat_addr%0d: got %h want %h", i, gaddr[i], 32'h1C00_0010 + 32'(4 * i));
            else passed++;
            total++;
            if (gcyc[i] != g + 1 + i) $display("FAIL zw_beat_cyc%0d: got %0d want %0d", i, gcyc[i], g + 1 + i);
            else passed++;
        end
        total++;
        if (d !== 128'h4444_4444_3333_3333_2222_2222_1111_1111)
            $display("FAIL zw_data: got %h want 44444444333333332222222211111111", d);
        else passed++;
        total++; if (p - g != NB + 2) $display("FAIL zw_latency: got %0d want %0d", p - g, NB + 2); else passed++;
        total++; if (w != 1) $display("FAIL zw_pulse_width: got %0d want 1", w); else passed++;
        total++; if (ga !== 1'b0) $display("FAIL zw_gnt_at_pulse: got %b want 0", ga); else passed++;
        total++; if (gb !== 1'b1) $display("FAIL zw_gnt_after_pulse: got %b want 1", gb); else passed++;
        use_table = 1'b0;
    endtask

    task automatic test_gnt_stall();
        logic [RW-1:0] d;
        int g, p, w;
        bit ga, gb, tmo;
        salt = $urandom();
        gnt_pct = 100; dly_min = 1; dly_max = 1;
        stall_beat = 2; stall_left = 3; hold_viol = 0;
        run_line(32'h1C00_0104, d, g, p, w, ga, gb, tmo);
        total++; if (tmo) $display("FAIL stall_timeout: no response within bound"); else passed++;
        total++; if (stall_left != 0) $display("FAIL stall_applied: left %0d want 0", stall_left); else passed++;
        total++; if (hold_viol != 0) $display("FAIL stall_hold: violations %0d want 0", hold_viol); else passed++;
        total++;
        if (gaddr.size() < 3 || gaddr[2] !== 32'h1C00_0108)
            $display("FAIL stall_beat2_addr: got %h want 1c000108", gaddr.size() >= 3 ? gaddr[2] : 32'h0);
        else passed++;
        total++;
        if (gcyc.size() < 3 || gcyc[2] - gcyc[1] != 4)
            $display("FAIL stall_gap: got %0d want 4", gcyc.size() >= 3 ? gcyc[2] - gcyc[1] : -1);
        else passed++;
        total++; if (d !== exp_line(32'h1C00_0104)) $display("FAIL stall_data: got %h want %h", d, exp_line(32'h1C00_0104)); else passed++;
        total++; if (p != last_rv_cyc + 1) $display("FAIL stall_latency: pulse %0d want %0d", p, last_rv_cyc + 1); else passed++;
        total++; if (p - g != NB + 5) $display("FAIL stall_total: got %0d want %0d", p - g, NB + 5); else passed++;
        stall_beat = -1;
    endtask

    task automatic test_back_to_back();
        logic [31:0]   a_addr, b_addr;
        logic [RW-1:0] ea, eb;
        logic [RW-1:0] dp[2];
        int            pc[2], gc[2];
        int grants, pulses, overlap, hold_bad;
        bit swap;
        salt = $urandom();
        gnt_pct = 100; dly_min = 1; dly_max = 1; stall_left = 0;
        a_addr = 32'h2000_0000 | ($urandom() & 32'h00FF_FFFF);
        b_addr = a_addr + 32'h40;
        ea = exp_line(a_addr);
        eb = exp_line(b_addr);
        grants = 0; pulses = 0; overlap = 0; hold_bad = 0; swap = 1'b0;
        gc[0] = -1; gc[1] = -1; pc[0] = -1; pc[1] = -100;
        dp[0] = '0; dp[1] = '0;
        refill_req = 1'b1;
        refill_addr = a_addr;
        for (int n = 0; n < 200 && pulses < 2; n++) begin
            if (swap) begin
                swap = 1'b0;
                if (grants == 1) refill_addr = b_addr;
                else refill_req = 1'b0;
            end
            if (refill_gnt === busy) overlap++;
            if (pulses == 1 && !refill_r_valid && refill_r_data !== ea) hold_bad++;
            if (refill_r_valid) begin
                if (pulses < 2) begin pc[pulses] = cyc; dp[pulses] = refill_r_data; end
                pulses++;
            end
            if (refill_req && refill_gnt) begin
                if (grants < 2) gc[grants] = cyc;
                grants++;
                swap = 1'b1;
            end
            @(negedge clk);
        end
        refill_req = 1'b0;
        total++; if (grants != 2) $display("FAIL b2b_grants: got %0d want 2", grants); else passed++;
        total++; if (pulses != 2) $display("FAIL b2b_pulses: got %0d want 2", pulses); else passed++;
        total++; if (gc[1] != pc[0] + 1) $display("FAIL b2b_regrant: got %0d want %0d", gc[1], pc[0] + 1); else passed++;
        total++; if (overlap != 0) $display("FAIL b2b_gnt_vs_busy: cycles %0d want 0", overlap); else passed++;
        total++; if (dp[0] !== ea) $display("FAIL b2b_line_a: got %h want %h", dp[0], ea); else passed++;
        total++; if (dp[1] !== eb) $display("FAIL b2b_line_b: got %h want %h", dp[1], eb); else passed++;
        total++; if (hold_bad != 0) $display("FAIL b2b_hold_a: cycles %0d want 0", hold_bad); else passed++;
        total++; if (pc[1] - gc[1] != NB + 2) $display("FAIL b2b_latency_b: got %0d want %0d", pc[1] - gc[1], NB + 2); else passed++;
        @(negedge clk);
    endtask

    task automatic test_delayed_resp();
        logic [RW-1:0] d;
        int g, p, w;
        bit ga, gb, tmo;
        salt = $urandom();
        gnt_pct = 100; dly_min = 5; dly_max = 5;
        stall_beat = 1; stall_left = 4;
        run_line(32'h1C01_2378, d, g, p, w, ga, gb, tmo);
        total++; if (tmo) $display("FAIL dly_timeout: no response within bound"); else passed++;
        total++;
        if (gcyc.size() < 2 || gcyc[1] != gcyc[0] + 5)
            $display("FAIL dly_overlap: beat1 grant %0d want %0d", gcyc.size() >= 2 ? gcyc[1] : -1, gcyc[0] + 5);
        else passed++;
        total++; if (d !== exp_line(32'h1C01_2378)) $display("FAIL dly_data: got %h want %h", d, exp_line(32'h1C01_2378)); else passed++;
        total++; if (p != last_rv_cyc + 1) $display("FAIL dly_latency: pulse %0d want %0d", p, last_rv_cyc + 1); else passed++;
        total++; if (p - g != 14) $display("FAIL dly_total: got %0d want 14", p - g); else passed++;
        stall_beat = -1;
        dly_min = 1; dly_max = 1;
    endtask

    task automatic test_random_lines();
        logic [RW-1:0] d;
        logic [31:0]   a, base;
        int g, p, w, bad_addr;
        bit ga, gb, tmo;
        gnt_pct = 60; dly_min = 1; dly_max = 6; stall_left = 0;
        for (int k = 0; k < 12; k++) begin
            salt = $urandom();
            a = $urandom();
            base = a & ~32'hF;
            run_line(a, d, g, p, w, ga, gb, tmo);
            bad_addr = (gaddr.size() == NB) ? 0 : 1;
            for (int i = 0; i < NB && i < gaddr.size(); i++)
                if (gaddr[i] !== base + 32'(4 * i)) bad_addr++;
            total++; if (tmo) $display("FAIL rnd%0d_timeout: no response", k); else passed++;
            total++; if (bad_addr != 0) $display("FAIL rnd%0d_addrs: bad %0d want 0", k, bad_addr); else passed++;
            total++; if (d !== exp_line(a)) $display("FAIL rnd%0d_data: got %h want %h", k, d, exp_line(a)); else passed++;
            total++; if (p != last_rv_cyc + 1 || w != 1) $display("FAIL rnd%0d_pulse: at %0d want %0d width %0d want 1", k, p, last_rv_cyc + 1, w); else passed++;
        end
        gnt_pct = 100; dly_min = 1; dly_max = 1;
    endtask

    task automatic test_spurious();
        logic [RW-1:0] prev, d;
        int rv_seen, chg, busy_seen, g, p, w;
        bit ga, gb, tmo;
        prev = refill_r_data;
        rv_seen = 0; chg = 0; busy_seen = 0;
        spur_data = 32'hDEAD_BEEF;
        spur_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (refill_r_valid) rv_seen++;
            if (refill_r_data !== prev) chg++;
            if (busy) busy_seen++;
        end
        total++; if (spur_req) $display("FAIL spur_injected: pending %b want 0", spur_req); else passed++;
        total++; if (rv_seen != 0) $display("FAIL spur_r_valid: cycles %0d want 0", rv_seen); else passed++;
        total++; if (chg != 0) $display("FAIL spur_r_data: changed %0d want 0", chg); else passed++;
        total++; if (busy_seen != 0) $display("FAIL spur_busy: cycles %0d want 0", busy_seen); else passed++;
        salt = $urandom();
        run_line(32'h1C00_0200, d, g, p, w, ga, gb, tmo);
        total++; if (d !== exp_line(32'h1C00_0200)) $display("FAIL spur_next_line: got %h want %h", d, exp_line(32'h1C00_0200)); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [RW-1:0] d;
        int g, p, w, n, rv_seen;
        bit ga, gb, tmo;
        salt = $urandom();
        gnt_pct = 100; dly_min = 5; dly_max = 5; stall_left = 0;
        gaddr.delete();
        gcyc.delete();
        refill_req = 1'b1;
        refill_addr = 32'h1C00_0300;
        n = 0;
        while (gaddr.size() < 2 && n < 50) begin
            @(negedge clk);
            if (!refill_gnt) refill_req = 1'b0;
            n++;
        end
        refill_req = 1'b0;
        @(negedge clk);
        total++; if (gaddr.size() < 2) $display("FAIL rst_mid_grants: got %0d want >=2", gaddr.size()); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL rst_mid_mem_req: got %b want 0", mem_req); else passed++;
        total++; if (refill_gnt !== 1'b1) $display("FAIL rst_mid_gnt: got %b want 1", refill_gnt); else passed++;
        total++; if (refill_r_data !== '0) $display("FAIL rst_mid_r_data: got %h want 0", refill_r_data); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 0;
        n = 0;
        while ((rspq.size() > 0 || mem_rv) && n < 40) begin
            @(negedge clk);
            if (refill_r_valid || busy) rv_seen++;
            n++;
        end
        repeat (2) @(negedge clk);
        total++; if (rspq.size() != 0) $display("FAIL rst_mid_drain: pending %0d want 0", rspq.size()); else passed++;
        total++; if (rv_seen != 0) $display("FAIL rst_mid_late_rvalid: reacted %0d want 0", rv_seen); else passed++;
        total++; if (refill_r_data !== '0) $display("FAIL rst_mid_data_after: got %h want 0", refill_r_data); else passed++;
        dly_min = 1; dly_max = 1;
        salt = $urandom();
        run_line(32'h1C00_0340, d, g, p, w, ga, gb, tmo);
        total++; if (tmo) $display("FAIL rst_mid_new_timeout: no response"); else passed++;
        total++; if (d !== exp_line(32'h1C00_0340)) $display("FAIL rst_mid_new_data: got %h want %h", d, exp_line(32'h1C00_0340)); else passed++;
        total++; if (p - g != NB + 2) $display("FAIL rst_mid_new_latency: got %0d want %0d", p - g, NB + 2); else passed++;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_gnt_stall();
        test_back_to_back();
        test_delayed_resp();
        test_random_lines();
        test_spurious();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
